// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, divider state encoding and the
// quotient value reported on divide-by-zero.
package alu_pkg;

    localparam int ALU_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic [ALU_W-1:0] DIV0_Q = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, quo} left, try subtracting the
// divisor, keep the difference if it did not go negative.
module div_step
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] b,
    output logic [W-1:0] rem_next,
    output logic [W-1:0] quo_next
);

    logic [W:0] shifted;
    logic [W:0] trial;

    // rem < b always holds, so a non-negative trial fits in W bits and a
    // negative one is flagged by the top bit of the W+1-bit difference.
    assign shifted = {rem, quo[W-1]};
    assign trial   = shifted - {1'b0, b};

    always_comb begin
        if (trial[W]) begin
            rem_next = shifted[W-1:0];
            quo_next = {quo[W-2:0], 1'b0};
        end else begin
            rem_next = trial[W-1:0];
            quo_next = {quo[W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_div_8bit.sv
// Sequential unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake, with a divide-by-zero shortcut.
module seq_div_8bit
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         busy,
    output logic         done,
    output logic         dz
);

    localparam int CNT_W = $clog2(W);

    div_state_t state, state_next;

    logic [W-1:0]     rem, quo, b_reg;
    logic [W-1:0]     rem_next, quo_next;
    logic [CNT_W-1:0] cnt;

    div_step #(.W(W)) u_step (
        .rem      (rem),
        .quo      (quo),
        .b        (b_reg),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: next state gets a default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (b == '0) ? DONE : CALC;
            CALC:    if (cnt == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem   <= '0;
            quo   <= '0;
            b_reg <= '0;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            dz    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        b_reg <= b;
                        if (b == '0) begin
                            q  <= DIV0_Q;
                            r  <= a;
                            dz <= 1'b1;
                        end else begin
                            rem <= '0;
                            quo <= a;
                            cnt <= CNT_W'(W - 1);
                        end
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt - 1'b1;
                    // Results are published only on entry to DONE.
                    if (cnt == '0) begin
                        q  <= quo_next;
                        r  <= rem_next;
                        dz <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_div_8bit.sv
// Scoreboard bench for seq_div_8bit: stimulus pushes expected results, a
// negedge monitor pops and compares on every done pulse.
module tb_seq_div_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic [7:0] q, r;
    logic       busy, done, dz;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         done_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    seq_div_8bit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .dz    (dz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("q", int'(q), int'(e.q));
                check("r", int'(r), int'(e.r));
                check("dz", int'(dz), int'(e.dz));
                check("done_cycle", cyc, e.done_cyc);
                if (e.b != 0) begin
                    check("identity", int'(q) * int'(e.b) + int'(r), int'(e.a));
                    check("r_lt_b", int'(r < e.b), 1);
                end
            end
        end
    end

    // Drives one accepted start; returns 1 time unit after the accept edge.
    task automatic issue(input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] qv, input logic [7:0] rv,
                         input logic dzv, input bit push);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e.a  = av;
            e.b  = bv;
            e.q  = qv;
            e.r  = rv;
            e.dz = dzv;
            e.done_cyc = (bv == 0) ? cyc : cyc + 8;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int t0;
        exp_t e;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_q", int'(q), 0);
        check("reset_r", int'(r), 0);
        check("reset_dz", int'(dz), 0);

        // 225/15: busy for exactly 9 cycles, done on the last of them.
        issue(8'd225, 8'd15, 8'd15, 8'd0, 1'b0, 1'b1);
        repeat (9) begin
            @(negedge clk);
            check("busy_during", int'(busy), 1);
        end
        @(negedge clk);
        check("busy_after", int'(busy), 0);
        wait_drain();

        issue(8'd200, 8'd7,  8'd28, 8'd4,  1'b0, 1'b1); wait_drain();
        issue(8'd255, 8'd16, 8'd15, 8'd15, 1'b0, 1'b1); wait_drain();
        issue(8'd81,  8'd9,  8'd9,  8'd0,  1'b0, 1'b1); wait_drain();
        issue(8'd9,   8'd0,  8'hFF, 8'd9,  1'b1, 1'b1); wait_drain();
        issue(8'd9,   8'd3,  8'd3,  8'd0,  1'b0, 1'b1); wait_drain();
        issue(8'd5,   8'd200, 8'd0, 8'd5,  1'b0, 1'b1); wait_drain();
        issue(8'd0,   8'd7,  8'd0,  8'd0,  1'b0, 1'b1); wait_drain();
        issue(8'd173, 8'd1,  8'd173, 8'd0, 1'b0, 1'b1); wait_drain();

        // Re-pulsed start during CALC must be ignored.
        issue(8'd158, 8'd10, 8'd15, 8'd8, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        a     = 8'd6;
        b     = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain();
        repeat (10) @(negedge clk);

        // Held start: second accept lands in the IDLE cycle after DONE.
        @(negedge clk);
        start = 1'b1;
        a     = 8'd100;
        b     = 8'd10;
        @(posedge clk);
        #1;
        t0 = cyc;
        e.a = 8'd100; e.b = 8'd10; e.q = 8'd10; e.r = 8'd0; e.dz = 1'b0; e.done_cyc = t0 + 8;
        sb.push_back(e);
        a = 8'd50;
        b = 8'd7;
        e.a = 8'd50; e.b = 8'd7; e.q = 8'd7; e.r = 8'd1; e.dz = 1'b0; e.done_cyc = t0 + 18;
        sb.push_back(e);
        repeat (10) @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain();

        // Reset mid-CALC discards the division.
        issue(8'd200, 8'd7, 8'd0, 8'd0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_q", int'(q), 0);
        check("abort_r", int'(r), 0);
        repeat (12) @(negedge clk);
        issue(8'd29, 8'd4, 8'd7, 8'd1, 1'b0, 1'b1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_div_8bit.md
Name: seq_div_8bit

Overview:
Sequential 8-bit unsigned restoring divider for the 8-bit ALU. It is the inverse operation of vedic_mul_8bit: a dividend and divisor go in, and a quotient and remainder come out. It produces one quotient bit per clock behind a start/busy/done handshake, and sits beside the multiplier in the ALU datapath under the ALU control FSM.

Parameters:
- W, 8, operand width in bits; quotient and remainder are also W bits.

Ports:
- clk    input   1  system clock; all state updates on the rising edge.
- rst    input   1  synchronous, active-high reset.
- start  input   1  request a division; sampled only when the block can accept it.
- a      input   W  dividend; sampled in the cycle start is accepted.
- b      input   W  divisor; sampled in the cycle start is accepted.
- q      output  W  quotient; valid while done=1 and held until the next accepted start.
- r      output  W  remainder; same validity rule as q.
- busy   output  1  high while a division is in progress (states CALC and DONE).
- done   output  1  one-cycle pulse when q, r and dz are valid.
- dz     output  1  divide-by-zero flag; valid with done, held like q and r.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state goes to IDLE.
  - q, r, internal remainder/quotient registers and the bit counter clear to 0.
  - busy=0, done=0, dz=0.
  - Reset takes priority over every other event, including mid-CALC; any partial result is discarded.
- States: IDLE, CALC, DONE.
- IDLE:
  - On start=1, latch a and b.
  - If b != 0: clear the working remainder, set the working quotient to a, set the counter to W-1, and go to CALC.
  - If b == 0: go to DONE with q=all-ones (8'hFF), r=a, dz=1.
- CALC, each cycle:
  - Shift {rem, quo} left by one.
  - Compute a trial value = shifted rem minus b, using a W+1-bit subtraction.
  - If the trial is non-negative, rem takes the trial value and quotient LSB=1; otherwise rem is kept (restore) and LSB=0.
  - The counter decrements; when the counter is 0, go to DONE and load q/r from the working registers with dz=0.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
- Latency:
  - b != 0: start accepted at edge T gives CALC for edges T+1..T+8 and done=1 in the cycle after edge T+8 (9 cycles after start).
  - b == 0: done=1 in the cycle after edge T (1 cycle).
- busy=1 from the edge after start is accepted up to and including the DONE cycle.
- start while busy=1 is ignored; operands are not re-sampled, including start asserted in the DONE cycle.
- q, r and dz hold their last values in IDLE; they change only when the DONE state is entered.
- Identities checked in every case with b != 0: a == q*b + r and r < b.
- Edge cases:
  - a < b gives q=0, r=a.
  - a == 0 gives q=0, r=0.
  - b == 1 gives q=a, r=0.
- Back-to-back operation: start held high continuously results in a new accept in the IDLE cycle after each DONE.

Decomposition:
- Shared package alu_pkg holds:
  - the width constant ALU_W=8;
  - the divider state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - the divide-by-zero quotient constant DIV0_Q = all-ones.
- One combinational sub-module, div_step, implements a single restoring step.
  - Inputs: rem, quo, b.
  - Outputs: next rem, next quo.
  - It is instantiated once in the top; the top contains the FSM, counter and output registers.

Test Plan:
- Divide 225 by 15 (inverse of 15*15) -> done 9 cycles after start, q=15, r=0, dz=0; busy high for 9 cycles.
- Divide 200 by 7 -> q=28, r=4; divide 255 by 16 -> q=15, r=15; divide 81 by 9 -> q=9, r=0; a==q*b+r checked each time.
- Divide 9 by 0 -> done 1 cycle after start, q=8'hFF, r=9, dz=1; the next divide 9 by 3 gives dz=0, q=3, r=0.
- Divide 5 by 200 (a<b) -> q=0, r=5; divide 0 by 7 -> q=0, r=0; divide 173 by 1 -> q=173, r=0.
- Divide 158 by 10 with start re-pulsed on 6 by 3 at CALC cycle 4 -> the second start is ignored, result q=15, r=8, exactly one done pulse.
- Divide 200 by 7 with rst=1 at CALC cycle 5 -> next cycle state IDLE, busy=0, done=0, q=0, r=0, no done pulse; a later divide 29 by 4 -> q=7, r=1.
